// File: rtl/uio_bus_arbiter_if.sv
// Bus bundle between the uio pad arbiter and its requesters/pads.
// The master modport is the arbiter's view; slave is the requester/pad side.
interface uio_bus_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_out;
  logic [8*NREQ-1:0] req_oe;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        rd_data;
  logic [7:0]        uio_in;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;
  logic              busy;

  modport master (
    input  req, req_out, req_oe, uio_in,
    output gnt, rd_data, uio_out, uio_oe, busy
  );

  modport slave (
    output req, req_out, req_oe, uio_in,
    input  gnt, rd_data, uio_out, uio_oe, busy
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner arbitration of the 8-bit uio pad bank, with tri-state
// turnaround between owners and a hold limit that preempts long owners.
module uio_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uio_bus_arbiter_if.master bus
);

  localparam int IDXW = $clog2(NREQ);
  localparam int HCW  = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_TURN = 2'b01,
    ST_OWN  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   sel_q, sel_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]        turn_cnt_q, turn_cnt_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [7:0]        uio_out_q, uio_out_d;
  logic [7:0]        uio_oe_q, uio_oe_d;
  logic [7:0]        rd_data_q;
  logic              busy_q;

  logic [NREQ-1:0]   sel_oh_s;
  logic              other_req_s;
  logic              exit_s;
  logic [IDXW-1:0]   pick_s;

  // First set request at index >= ptr, wrapping modulo NREQ.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDXW-1:0] ptr);
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] res;
    logic            found;
    res   = {IDXW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum   = {1'b0, ptr} + (IDXW+1)'(k);
      sum   = (sum >= (IDXW+1)'(NREQ)) ? sum - (IDXW+1)'(NREQ) : sum;
      idx   = sum[IDXW-1:0];
      res   = (!found && r[idx]) ? idx : res;
      found = found | r[idx];
    end
    return res;
  endfunction

  // Owner decode, preemption condition and next round-robin candidate.
  always_comb begin
    sel_oh_s    = {{(NREQ-1){1'b0}}, 1'b1} << sel_q;
    other_req_s = |(bus.req & ~sel_oh_s);
    exit_s      = !bus.req[sel_q] ||
                  ((hold_cnt_q >= HCW'(MAX_HOLD - 1)) && other_req_s);
    pick_s      = rr_pick(bus.req, rr_ptr_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    turn_cnt_d = turn_cnt_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    uio_out_d  = uio_out_q;
    uio_oe_d   = 8'h00;

    case (state_q)
      ST_IDLE: begin
        gnt_d = {NREQ{1'b0}};
        if (|bus.req) begin
          sel_d      = pick_s;
          turn_cnt_d = 2'(TURN_CYC - 1);
          state_d    = ST_TURN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_TURN: begin
        gnt_d = {NREQ{1'b0}};
        if (!bus.req[sel_q]) begin
          state_d = ST_IDLE;
        end else if (turn_cnt_q == 2'd0) begin
          state_d    = ST_OWN;
          gnt_d      = sel_oh_s;
          hold_cnt_d = {HCW{1'b0}};
          rr_ptr_d   = (sel_q == IDXW'(NREQ - 1)) ? {IDXW{1'b0}} : sel_q + IDXW'(1);
        end else begin
          turn_cnt_d = turn_cnt_q - 2'd1;
        end
      end

      ST_OWN: begin
        uio_out_d = bus.req_out[{sel_q, 3'b000} +: 8];
        if (exit_s) begin
          gnt_d = {NREQ{1'b0}};
          if (|bus.req) begin
            sel_d      = pick_s;
            turn_cnt_d = 2'(TURN_CYC - 1);
            state_d    = ST_TURN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          uio_oe_d   = bus.req_oe[{sel_q, 3'b000} +: 8];
          hold_cnt_d = (hold_cnt_q == HCW'(MAX_HOLD)) ? hold_cnt_q : hold_cnt_q + HCW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = {NREQ{1'b0}};
      end
    endcase
  end

  // State and output registers; reset tri-states the pads on the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= {IDXW{1'b0}};
      rr_ptr_q   <= {IDXW{1'b0}};
      turn_cnt_q <= 2'd0;
      hold_cnt_q <= {HCW{1'b0}};
      gnt_q      <= {NREQ{1'b0}};
      uio_out_q  <= 8'h00;
      uio_oe_q   <= 8'h00;
      rd_data_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      turn_cnt_q <= turn_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      uio_out_q  <= uio_out_d;
      uio_oe_q   <= uio_oe_d;
      rd_data_q  <= bus.uio_in;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.uio_out = uio_out_q;
  assign bus.uio_oe  = uio_oe_q;
  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter (NREQ=4, TURN_CYC=1, MAX_HOLD=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uio_bus_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  uio_bus_arbiter_if #(.NREQ(4)) bus ();

  uio_bus_arbiter #(
    .NREQ(4),
    .TURN_CYC(1),
    .MAX_HOLD(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.req     = 4'b0000;
    bus.req_out = 32'h0000_0000;
    bus.req_oe  = 32'h0000_0000;
    bus.uio_in  = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    repeat (2) @(negedge clk);
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
    checks++; if (bus.uio_oe !== 8'h00) begin errors++; $display("FAIL reset_oe: got %h expected 00", bus.uio_oe); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd: got %h expected 00", bus.rd_data); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL reset_turn: gnt %b busy %b expected 0000/1", bus.gnt, bus.busy); end
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b expected 0001", bus.gnt); end
  endtask

  task automatic test_single_owner();
    do_reset();
    bus.req_out[23:16] = 8'hA5;
    bus.req_oe[23:16]  = 8'hFF;
    bus.req            = 4'b0100;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_turn: gnt %b busy %b expected 0000/1", bus.gnt, bus.busy); end
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", bus.gnt); end
    checks++; if (bus.uio_oe !== 8'h00) begin errors++; $display("FAIL single_oe_first: got %h expected 00", bus.uio_oe); end
    bus.uio_in = 8'h3C;
    @(negedge clk);
    checks++; if (bus.uio_out !== 8'hA5) begin errors++; $display("FAIL single_out: got %h expected a5", bus.uio_out); end
    checks++; if (bus.uio_oe !== 8'hFF) begin errors++; $display("FAIL single_oe: got %h expected ff", bus.uio_oe); end
    checks++; if (bus.rd_data !== 8'h3C) begin errors++; $display("FAIL single_rd: got %h expected 3c", bus.rd_data); end
    bus.req_oe[23:16] = 8'h0F;
    @(negedge clk);
    checks++; if (bus.uio_oe !== 8'h0F) begin errors++; $display("FAIL single_oe_pass: got %h expected 0f", bus.uio_oe); end
    bus.req = 4'b0000;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0000 || bus.uio_oe !== 8'h00 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL single_release: gnt %b oe %h busy %b expected 0000/00/0", bus.gnt, bus.uio_oe, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    int n;
    int hold;
    int gap;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_out[8*i +: 8] = 8'h10 + 8'(i);
      bus.req_oe[8*i +: 8]  = 8'hF0 | 8'(i);
    end
    bus.req = 4'b1111;
    n = 0;
    while (bus.gnt !== 4'b0001 && n < 10) begin @(negedge clk); n++; end
    checks++; if (n != 2) begin errors++; $display("FAIL rr_first_latency: got %0d expected 2", n); end
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      checks++; if (bus.gnt !== exp_gnt) begin errors++; $display("FAIL rr_order%0d: got %b expected %b", k, bus.gnt, exp_gnt); end
      hold = 0;
      while (bus.gnt === exp_gnt && hold < 40) begin
        if (hold == 1) begin
          checks++; if (bus.uio_out !== 8'h10 + 8'(k % 4) || bus.uio_oe !== (8'hF0 | 8'(k % 4))) begin
            errors++; $display("FAIL rr_data%0d: out %h oe %h expected %h/%h", k, bus.uio_out, bus.uio_oe, 8'h10 + 8'(k % 4), 8'hF0 | 8'(k % 4));
          end
        end
        @(negedge clk);
        hold++;
      end
      checks++; if (hold != 16) begin errors++; $display("FAIL rr_hold%0d: got %0d expected 16", k, hold); end
      gap = 0;
      while (bus.gnt === 4'b0000 && gap < 10) begin
        checks++; if (bus.uio_oe !== 8'h00) begin errors++; $display("FAIL rr_gap_oe%0d: got %h expected 00", k, bus.uio_oe); end
        @(negedge clk);
        gap++;
      end
      checks++; if (gap != 1) begin errors++; $display("FAIL rr_gap%0d: got %0d expected 1", k, gap); end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_no_preempt();
    do_reset();
    bus.req = 4'b0010;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL alone_gnt c%0d: got %b expected 0010", c, bus.gnt); end
      @(negedge clk);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_early_release();
    do_reset();
    bus.req_out[31:24] = 8'h77;
    bus.req_oe[31:24]  = 8'h81;
    bus.req            = 4'b1001;
    repeat (2) @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL early_gnt0: got %b expected 0001", bus.gnt); end
    repeat (3) @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL early_hold0: got %b expected 0001", bus.gnt); end
    bus.req = 4'b1000;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0000 || bus.uio_oe !== 8'h00 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL early_exit: gnt %b oe %h busy %b expected 0000/00/1", bus.gnt, bus.uio_oe, bus.busy);
    end
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL early_gnt3: got %b expected 1000", bus.gnt); end
    @(negedge clk);
    checks++; if (bus.uio_out !== 8'h77 || bus.uio_oe !== 8'h81) begin
      errors++; $display("FAIL early_data3: out %h oe %h expected 77/81", bus.uio_out, bus.uio_oe);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_turn_drop();
    do_reset();
    bus.req = 4'b0001;
    repeat (2) @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL drop_gnt0: got %b expected 0001", bus.gnt); end
    bus.req = 4'b0000;
    @(negedge clk);
    bus.req = 4'b0100;
    @(negedge clk);
    bus.req = 4'b0000;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL drop_idle: gnt %b busy %b expected 0000/0", bus.gnt, bus.busy);
    end
    bus.req = 4'b0011;
    repeat (2) @(negedge clk);
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL drop_rrptr: got %b expected 0010", bus.gnt); end
    bus.req = 4'b0000;
  endtask

  task automatic test_reset_mid_own();
    do_reset();
    bus.req_out[7:0] = 8'h5A;
    bus.req_oe[7:0]  = 8'hFF;
    bus.req          = 4'b0001;
    repeat (3) @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001 || bus.uio_oe !== 8'hFF) begin
      errors++; $display("FAIL midrst_pre: gnt %b oe %h expected 0001/ff", bus.gnt, bus.uio_oe);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0000 || bus.uio_oe !== 8'h00 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_post: gnt %b oe %h busy %b expected 0000/00/0", bus.gnt, bus.uio_oe, bus.busy);
    end
    checks++; if (bus.uio_out !== 8'h00) begin errors++; $display("FAIL midrst_out: got %h expected 00", bus.uio_out); end
    bus.req = 4'b0000;
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.req     = 4'b0000;
    bus.req_out = 32'h0000_0000;
    bus.req_oe  = 32'h0000_0000;
    bus.uio_in  = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_owner();
    test_round_robin();
    test_no_preempt();
    test_early_release();
    test_turn_drop();
    test_reset_mid_own();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
